// File: rtl/apb_defs.sv
// Shared APB completer definitions: FSM state encoding, bus width defaults
// and the number of completers on the bus.
package apb_defs;

  localparam int APB_DATA_WIDTH = 16;
  localparam int APB_ADDR_WIDTH = 8;
  localparam int TOTAL_SLAVES   = 1;
  localparam int WAIT_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_ctrl.sv
// Access-phase sequencer: counts programmed wait states, drives pready and
// flags the response-load, response-drop and commit points for the register bank.
module apb_wait_ctrl
  import apb_defs::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic       apb_clk,
  input  logic       apb_rst,
  input  logic       setup,
  input  logic       access,
  input  logic       psel,
  output logic       pready,
  output logic       commit,
  output logic       rsp_load,
  output logic       rsp_drop,
  output apb_state_e state
);

  localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

  logic [WAIT_CNT_W-1:0] cnt;

  // rsp_load marks the edge that raises pready; rsp_drop the edge that clears it.
  always_comb begin
    rsp_load = 1'b0;
    rsp_drop = 1'b0;
    commit   = 1'b0;
    case (state)
      ST_IDLE: rsp_load = setup && (WS == '0);
      ST_WAIT: begin
        if (!psel) begin
          rsp_drop = 1'b1;
        end else if (access && cnt == WAIT_CNT_W'(1)) begin
          rsp_load = 1'b1;
        end
      end
      ST_READY: begin
        if (!psel) begin
          rsp_drop = 1'b1;
        end else if (access && pready) begin
          commit   = 1'b1;
          rsp_drop = 1'b1;
        end
      end
      default: rsp_drop = 1'b1;
    endcase
  end

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      pready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            cnt   <= WS;
            state <= (WS == '0) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else if (access) begin
            if (cnt == WAIT_CNT_W'(1)) state <= ST_READY;
            else                       cnt   <= cnt - 1'b1;
          end
        end
        ST_READY: begin
          if (!psel || access) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (rsp_load)      pready <= 1'b1;
      else if (rsp_drop) pready <= 1'b0;
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a local register bank (reg 0 = read-only ID) and programmable
// wait states. Define APB_PSTRB_EN to add the pstrb byte-strobe port.
module apb_slave_regfile
  import apb_defs::*;
#(
  parameter int                    DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 16'hA5B0
) (
  input  logic                           apb_clk,
  input  logic                           apb_rst,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
`endif
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat,
  output logic                           wr_pulse
);

  localparam int NB = DATA_WIDTH / 8;

  // Handshake: a setup cycle (psel & ~penable) is accepted only in IDLE; the
  // transfer completes on the edge where psel, penable and pready are all high.
  logic            setup, access, accept, commit, rsp_load, rsp_drop;
  apb_state_e      fsm_state;
  logic [ADDR_WIDTH-1:0] paddr_q, eff_addr;
  logic            pwrite_q, eff_write, err_now, wr_commit;
  logic [DATA_WIDTH-1:0] pwdata_q, rd_val;
  logic [NB-1:0]   wr_strb;
  logic [DATA_WIDTH-1:0] rw_q     [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];

  assign setup  = psel && !penable;
  assign access = psel && penable;
  assign accept = setup && (fsm_state == ST_IDLE);

  apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait_ctrl (
    .apb_clk  (apb_clk),
    .apb_rst  (apb_rst),
    .setup    (setup),
    .access   (access),
    .psel     (psel),
    .pready   (pready),
    .commit   (commit),
    .rsp_load (rsp_load),
    .rsp_drop (rsp_drop),
    .state    (fsm_state)
  );

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else if (accept) begin
      paddr_q  <= paddr;
      pwrite_q <= pwrite;
      pwdata_q <= pwdata;
    end
  end

  // With zero wait states the response loads on the setup edge itself, so the
  // live bus fields are decoded there instead of the latched copies.
  assign eff_addr  = accept ? paddr  : paddr_q;
  assign eff_write = accept ? pwrite : pwrite_q;

`ifdef APB_PSTRB_EN
  logic [NB-1:0] strb_q, eff_strb;

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst)     strb_q <= '0;
    else if (accept) strb_q <= pstrb;
  end

  assign eff_strb = accept ? pstrb : strb_q;
  assign wr_strb  = strb_q;
  assign err_now  = !addr_ok(eff_addr) || (eff_write && eff_addr == '0) ||
                    (!eff_write && eff_strb != '0);
`else
  assign wr_strb  = '1;
  assign err_now  = !addr_ok(eff_addr) || (eff_write && eff_addr == '0);
`endif

  // pslverr was captured with pready, so it still qualifies the write at commit.
  assign wr_commit = commit && pwrite_q && !pslverr;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(eff_addr) == 32'(i)) rd_val = reg_view[i];
    end
  end

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      prdata   <= '0;
      pslverr  <= 1'b0;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= wr_commit;
      if (rsp_load) begin
        prdata  <= (eff_write || err_now) ? '0 : rd_val;
        pslverr <= err_now;
      end else if (rsp_drop) begin
        pslverr <= 1'b0;
      end
    end
  end

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      for (int i = 1; i < NUM_REGS; i++) rw_q[i] <= '0;
    end else if (wr_commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (32'(paddr_q) == 32'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) rw_q[i][b*8 +: 8] <= pwdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

  assign reg_view[0] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_view
    assign reg_view[g] = rw_q[g];
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_flat[g*DATA_WIDTH +: DATA_WIDTH] = reg_view[g];
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB completer (slave end) for the APB interface driven by the team's APB master path. It decodes one PSEL line, services read and write transfers against a local register bank, and inserts a programmable number of wait states. It reports errors for bad accesses. It is the standard endpoint used to bring up and verify the master, and a template for real peripherals.

Parameters:
DATA_WIDTH, 16, PWDATA/PRDATA width; must be a multiple of 8.
ADDR_WIDTH, 8, PADDR width; PADDR is a word index, not a byte address.
NUM_REGS, 16, number of registers; index 0 is read-only ID, 1..NUM_REGS-1 are read/write.
WAIT_STATES, 0, access-phase cycles with PREADY low before completion; range 0..15.
ID_VALUE, 16'hA5B0, constant returned by register 0.

Ports:
apb_clk  in  1  APB clock; all logic on rising edge.
apb_rst  in  1  asynchronous, active-high reset.
psel  in  1  this slave selected.
penable  in  1  access phase.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_WIDTH  register index.
pwdata  in  DATA_WIDTH  write data.
prdata  out  DATA_WIDTH  read data, registered.
pready  out  1  transfer complete, registered.
pslverr  out  1  error response; valid only while pready=1.
reg_flat  out  NUM_REGS*DATA_WIDTH  all register contents; register i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
wr_pulse  out  1  one-cycle pulse on each committed write.

Behaviour:
- Clock and reset: one clock, apb_clk. Reset apb_rst is asynchronous and active-high.
- Reset values: prdata=0, pready=0, pslverr=0, wr_pulse=0, R/W registers=0, FSM=IDLE.
- Reset mid-transfer aborts the transfer; no register is modified.
- FSM states: IDLE, WAIT, READY.
  - IDLE: on setup (psel & ~penable), latch paddr/pwrite/pwdata and load wait counter = WAIT_STATES.
    - WAIT_STATES=0: go to READY and set pready=1 on the same edge, so pready is high in the first access cycle.
    - Otherwise go to WAIT.
  - IDLE: penable=1 without a preceding setup is a protocol violation; ignore it and stay in IDLE.
  - WAIT: each cycle with psel & penable, decrement the counter. When it reaches 1, set pready=1 and go to READY. Total access-phase length is WAIT_STATES+1 cycles.
  - WAIT or READY: psel=0 aborts to IDLE, pready=0, no commit.
  - READY: on psel & penable & pready, the transfer completes.
    - Commit the write, if legal, at this edge; wr_pulse=1 the next cycle.
    - Clear pready and go to IDLE.
    - Back-to-back: a setup in the cycle after completion is accepted normally.
- Latched signals: pwrite, paddr and pwdata are sampled only at setup. Changes during the access phase are ignored.
- prdata: loaded on the edge that sets pready=1, with reg[idx] for a legal read and 0 for an error. Holds that value until the next completion.
- pslverr: set together with pready, cleared with pready. It is 1 when:
  - idx >= NUM_REGS, or
  - write to idx 0.
  An erroring write modifies nothing and produces no wr_pulse.
- Index compare uses the full ADDR_WIDTH, with no truncation or aliasing. When NUM_REGS > 2^ADDR_WIDTH, upper registers are unreachable but remain legal.

Optional Feature:
APB_PSTRB_EN. When defined:
- Adds input port pstrb [DATA_WIDTH/8-1:0], latched at setup.
- A committed write updates only the bytes whose strobe bit is 1.
- A read with pstrb != 0 returns pslverr=1.
When undefined: the port is absent and every write updates all bytes.

Decomposition:
- Shared package/include apb_defs: FSM state encodings (IDLE/WAIT/READY), DATA_WIDTH/ADDR_WIDTH defaults, the `total_slave count.
- One natural sub-module, apb_wait_ctrl: the wait counter plus pready/FSM sequencing. It has inputs setup/access/psel and outputs pready/commit. The register bank and decode stay in the top module.

Test Plan:
- WAIT_STATES=0: write idx 3 = 16'h1234, then read idx 3 -> pready high in the first access cycle, prdata=16'h1234, pslverr=0, wr_pulse once.
- WAIT_STATES=3: read idx 0 -> pready low for 3 access cycles, high in the 4th, prdata=16'hA5B0.
- Write idx 0 = 16'hFFFF, and read idx 20 with NUM_REGS=16 -> pslverr=1 with pready, reg 0 unchanged, prdata=0, no wr_pulse.
- psel dropped in the 2nd wait cycle (WAIT_STATES=3) of a write 16'h00FF to idx 5 -> pready never rises, reg 5 stays 0, the next transfer completes normally.
- apb_rst asserted asynchronously mid-wait -> pready/prdata/pslverr go to 0 immediately, all registers 0. Back-to-back writes idx 1, 2 with no idle cycle -> both commit, two wr_pulses.
- With APB_PSTRB_EN: reg 4 = 16'hAAAA, write 16'h5555 with pstrb=2'b01 -> reg 4 = 16'hAA55.
